// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cond_pkg
//  Purpose  : Shared types and constants for the execute-stage conditional
//             unit: condition-field encodings, NZCV bit positions and the
//             FlagW group bit positions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cond_pkg;

    // ARMv4 condition field encodings, bits [31:28] of the instruction
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Bit positions inside FlagW
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage
`default_nettype wire

// File: rtl/cond_unit_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit_pipe_if
//  Purpose  : Bundles the execute-stage control inputs and the gated
//             outputs / status of the conditional unit.
//  Ports    : master - drives instruction controls, observes results
//             slave  - the conditional unit itself
//  Revision : 1.0  initial release
// ============================================================================
interface cond_unit_pipe_if #(
    parameter int CNT_W = 16
);
    // Instruction / pipeline controls
    logic             Valid;
    logic             Stall;
    logic             Flush;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;

    // Gated results and status
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic             Undef;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] TakenCnt;
    logic [CNT_W-1:0] SkipCnt;

    modport master (
        output Valid, Stall, Flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Undef,
               Flags, TakenCnt, SkipCnt
    );

    modport slave (
        input  Valid, Stall, Flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Undef,
               Flags, TakenCnt, SkipCnt
    );

endinterface
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cond_eval
//  Purpose  : Purely combinational ARMv4 condition decode. Evaluates the
//             4-bit condition field against the stored NZCV flags.
//  Ports    : cond_i  [3:0] condition field
//             flags_i [3:0] stored {N,Z,C,V}
//             pass_o        condition holds
//             undef_o       condition field is the undefined 4'b1111 encoding
//  Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o,
    output logic       undef_o
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = flags_i[N_BIT];
    assign w_z  = flags_i[Z_BIT];
    assign w_c  = flags_i[C_BIT];
    assign w_v  = flags_i[V_BIT];
    assign w_ge = (w_n == w_v);

    always_comb begin
        pass_o  = 1'b0;
        undef_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = w_z;
            COND_NE: pass_o = ~w_z;
            COND_CS: pass_o = w_c;
            COND_CC: pass_o = ~w_c;
            COND_MI: pass_o = w_n;
            COND_PL: pass_o = ~w_n;
            COND_VS: pass_o = w_v;
            COND_VC: pass_o = ~w_v;
            COND_HI: pass_o = w_c & ~w_z;
            COND_LS: pass_o = ~(w_c & ~w_z);
            COND_GE: pass_o = w_ge;
            COND_LT: pass_o = ~w_ge;
            COND_GT: pass_o = ~w_z & w_ge;
            COND_LE: pass_o = ~(~w_z & w_ge);
            COND_AL: pass_o = 1'b1;
            // Undefined encoding: never passes, always reported.
            COND_NV: undef_o = 1'b1;
            default: begin
                pass_o  = 1'b0;
                undef_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit_pipe
//  Purpose  : Execute-stage conditional unit. Owns the NZCV register,
//             evaluates the condition field against the stored flags,
//             gates PC/register/memory writes and the flag update, handles
//             stall/flush, optionally registers the gated outputs and keeps
//             saturating taken/skipped counters.
//  Ports    : clk   core clock, rising edge
//             reset asynchronous active-high reset
//             bus   cond_unit_pipe_if.slave (controls in, gated results out)
//  Revision : 1.0  initial release
// ============================================================================
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int         REG_OUT   = 0,
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic            clk,
    input  logic            reset,
    cond_unit_pipe_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_live;
    logic             w_pass;
    logic             w_undef;
    logic             w_cond_ex;
    logic             w_undef_g;
    logic             w_pcsrc;
    logic             w_regwrite;
    logic             w_memwrite;

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] taken_d;
    logic [CNT_W-1:0] skip_q;
    logic [CNT_W-1:0] skip_d;

    // ------------------------------------------------------------------
    // Condition evaluation always uses the stored flags, never ALUFlags.
    // ------------------------------------------------------------------
    cond_eval u_eval (
        .cond_i  (bus.Cond),
        .flags_i (flags_q),
        .pass_o  (w_pass),
        .undef_o (w_undef)
    );

    // Flush dominates Stall; both turn the slot into a bubble.
    assign w_live     = bus.Valid & ~bus.Stall & ~bus.Flush;
    assign w_cond_ex  = w_live & w_pass;
    assign w_undef_g  = w_live & w_undef;
    assign w_pcsrc    = bus.PCS  & w_cond_ex;
    assign w_regwrite = bus.RegW & w_cond_ex & ~bus.NoWrite;
    assign w_memwrite = bus.MemW & w_cond_ex;

    // ------------------------------------------------------------------
    // Flag register: each group loads only when its FlagW bit is set and
    // the instruction actually executes.
    // ------------------------------------------------------------------
    always_comb begin
        flags_d = flags_q;
        if (w_cond_ex) begin
            if (bus.FlagW[FLAGW_NZ]) begin
                flags_d[N_BIT] = bus.ALUFlags[N_BIT];
                flags_d[Z_BIT] = bus.ALUFlags[Z_BIT];
            end
            if (bus.FlagW[FLAGW_CV]) begin
                flags_d[C_BIT] = bus.ALUFlags[C_BIT];
                flags_d[V_BIT] = bus.ALUFlags[V_BIT];
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters; undefined conditions count as
    // skipped because pass is 0 for them.
    // ------------------------------------------------------------------
    always_comb begin
        taken_d = taken_q;
        skip_d  = skip_q;
        if (w_live) begin
            if (w_pass) begin
                if (taken_q != CNT_MAX) begin
                    taken_d = taken_q + CNT_W'(1);
                end
            end else begin
                if (skip_q != CNT_MAX) begin
                    skip_d = skip_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
            taken_q <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            taken_q <= taken_d;
            skip_q  <= skip_d;
        end
    end

    assign bus.Flags    = flags_q;
    assign bus.TakenCnt = taken_q;
    assign bus.SkipCnt  = skip_q;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (REG_OUT != 0) begin : g_reg_out
            // {PCSrc, RegWrite, MemWrite, CondEx, Undef}
            logic [4:0] out_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                end else if (bus.Flush) begin
                    out_q <= '0;
                end else if (!bus.Stall) begin
                    out_q <= {w_pcsrc, w_regwrite, w_memwrite,
                              w_cond_ex, w_undef_g};
                end
            end

            assign bus.PCSrc    = out_q[4];
            assign bus.RegWrite = out_q[3];
            assign bus.MemWrite = out_q[2];
            assign bus.CondEx   = out_q[1];
            assign bus.Undef    = out_q[0];
        end else begin : g_comb_out
            assign bus.PCSrc    = w_pcsrc;
            assign bus.RegWrite = w_regwrite;
            assign bus.MemWrite = w_memwrite;
            assign bus.CondEx   = w_cond_ex;
            assign bus.Undef    = w_undef_g;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cond_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_unit_pipe
//  Purpose  : Directed self-checking bench for cond_unit_pipe. Instance A is
//             the combinational-output build (REG_OUT=0, CNT_W=16, reset
//             flags 0000); instance B is the registered-output build
//             (REG_OUT=1, CNT_W=2, reset flags 0110).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_unit_pipe;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    cond_unit_pipe_if #(.CNT_W(16)) a ();
    cond_unit_pipe_if #(.CNT_W(2))  b ();

    cond_unit_pipe #(
        .REG_OUT   (0),
        .CNT_W     (16),
        .FLAGS_RST (4'b0000)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a)
    );

    cond_unit_pipe #(
        .REG_OUT   (1),
        .CNT_W     (2),
        .FLAGS_RST (4'b0110)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        a.Valid = 0; a.Stall = 0; a.Flush = 0; a.Cond = 4'h0; a.ALUFlags = 4'h0;
        a.FlagW = 2'b00; a.PCS = 0; a.RegW = 0; a.MemW = 0; a.NoWrite = 0;
        b.Valid = 0; b.Stall = 0; b.Flush = 0; b.Cond = 4'h0; b.ALUFlags = 4'h0;
        b.FlagW = 2'b00; b.PCS = 0; b.RegW = 0; b.MemW = 0; b.NoWrite = 0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---------------- reset state ----------------
        chk("a_rst_flags",  a.Flags,    4'h0);
        chk("a_rst_taken",  a.TakenCnt, 0);
        chk("a_rst_skip",   a.SkipCnt,  0);
        chk("a_rst_condex", a.CondEx,   0);
        chk("b_rst_flags",  b.Flags,    4'h6);
        chk("b_rst_regw",   b.RegWrite, 0);

        // ---------------- A: AL with full flag write ----------------
        a.Valid = 1; a.Cond = 4'hE; a.PCS = 1; a.RegW = 1; a.FlagW = 2'b11; a.ALUFlags = 4'b0100;
        #1;
        chk("a_al_pcsrc",   a.PCSrc,    1);
        chk("a_al_regw",    a.RegWrite, 1);
        chk("a_al_condex",  a.CondEx,   1);
        chk("a_al_memw",    a.MemWrite, 0);
        chk("a_al_nobyp",   a.Flags,    4'h0);
        tick();
        chk("a_al_flags",   a.Flags,    4'b0100);
        chk("a_al_taken",   a.TakenCnt, 1);

        // ---------------- A: EQ then NE with Z=1 ----------------
        a.PCS = 0; a.RegW = 0; a.FlagW = 2'b00; a.Cond = 4'h0;
        #1;
        chk("a_eq_condex",  a.CondEx,   1);
        tick();
        chk("a_eq_skip",    a.SkipCnt,  0);
        a.Cond = 4'h1;
        #1;
        chk("a_ne_condex",  a.CondEx,   0);
        tick();
        chk("a_ne_skip",    a.SkipCnt,  1);
        chk("a_ne_taken",   a.TakenCnt, 2);

        // ---------------- A: NZ-only write, CV held ----------------
        a.Cond = 4'hE; a.FlagW = 2'b10; a.ALUFlags = 4'b1011;
        tick();
        chk("a_nz_flags",   a.Flags,    4'b1000);
        a.Cond = 4'hB; a.FlagW = 2'b00; a.RegW = 1; a.NoWrite = 1; a.MemW = 1;
        #1;
        chk("a_lt_condex",  a.CondEx,   1);
        chk("a_lt_nowrite", a.RegWrite, 0);
        chk("a_lt_memw",    a.MemWrite, 1);
        a.Cond = 4'hC;              // GT: Z=0 but N!=V
        #1;
        chk("a_gt_condex",  a.CondEx,   0);
        a.Cond = 4'hB;
        tick();
        chk("a_lt_taken",   a.TakenCnt, 4);

        // ---------------- A: undefined condition ----------------
        a.Cond = 4'hF; a.PCS = 1; a.RegW = 1; a.MemW = 1; a.NoWrite = 0;
        a.FlagW = 2'b11; a.ALUFlags = 4'b0110;
        #1;
        chk("a_nv_undef",   a.Undef,    1);
        chk("a_nv_condex",  a.CondEx,   0);
        chk("a_nv_pcsrc",   a.PCSrc,    0);
        chk("a_nv_regw",    a.RegWrite, 0);
        chk("a_nv_memw",    a.MemWrite, 0);
        tick();
        chk("a_nv_flags",   a.Flags,    4'b1000);
        chk("a_nv_skip",    a.SkipCnt,  2);
        a.Valid = 0;
        #1;
        chk("a_bub_undef",  a.Undef,    0);

        // ---------------- A: stall and flush ----------------
        a.Valid = 1; a.Stall = 1; a.Cond = 4'hE; a.FlagW = 2'b11; a.ALUFlags = 4'b0111;
        #1;
        chk("a_stl_condex", a.CondEx,   0);
        chk("a_stl_pcsrc",  a.PCSrc,    0);
        chk("a_stl_regw",   a.RegWrite, 0);
        chk("a_stl_memw",   a.MemWrite, 0);
        tick();
        chk("a_stl_flags",  a.Flags,    4'b1000);
        chk("a_stl_taken",  a.TakenCnt, 4);
        chk("a_stl_skip",   a.SkipCnt,  2);
        a.Stall = 0; a.Flush = 1;
        #1;
        chk("a_fl_condex",  a.CondEx,   0);
        chk("a_fl_regw",    a.RegWrite, 0);
        tick();
        chk("a_fl_flags",   a.Flags,    4'b1000);
        chk("a_fl_taken",   a.TakenCnt, 4);
        chk("a_fl_skip",    a.SkipCnt,  2);
        a.Valid = 0; a.Flush = 0;

        // ---------------- B: registered outputs, saturation ----------------
        b.Valid = 1; b.Cond = 4'hE; b.RegW = 1;
        #1;
        chk("b_lat_before", b.RegWrite, 0);
        tick();
        chk("b_lat_regw",   b.RegWrite, 1);
        chk("b_lat_condex", b.CondEx,   1);
        chk("b_taken1",     b.TakenCnt, 1);
        tick();
        tick();
        chk("b_taken3",     b.TakenCnt, 3);
        tick();
        tick();
        chk("b_taken_sat",  b.TakenCnt, 3);
        chk("b_skip0",      b.SkipCnt,  0);

        b.Flush = 1;
        tick();
        chk("b_fl_regw",    b.RegWrite, 0);
        chk("b_fl_taken",   b.TakenCnt, 3);
        b.Flush = 0;
        tick();
        chk("b_al_regw",    b.RegWrite, 1);

        b.Stall = 1; b.Cond = 4'hF;
        tick();
        chk("b_stl_regw",   b.RegWrite, 1);
        chk("b_stl_undef",  b.Undef,    0);
        b.Stall = 0;
        tick();
        chk("b_nv_undef",   b.Undef,    1);
        chk("b_nv_regw",    b.RegWrite, 0);
        chk("b_nv_skip",    b.SkipCnt,  1);

        b.Cond = 4'hE; b.FlagW = 2'b11; b.ALUFlags = 4'b1001;
        tick();
        chk("b_wr_flags",   b.Flags,    4'b1001);
        chk("b_wr_regw",    b.RegWrite, 1);

        // ---------------- B: asynchronous reset mid-cycle ----------------
        b.Valid = 0; b.FlagW = 2'b00;
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_ar_regw",    b.RegWrite, 0);
        chk("b_ar_flags",   b.Flags,    4'h6);
        chk("b_ar_taken",   b.TakenCnt, 0);
        chk("b_ar_skip",    b.SkipCnt,  0);
        #1;
        rst_b = 1'b0;
        b.Valid = 1; b.Cond = 4'h0; b.RegW = 1;
        tick();
        chk("b_post_condex", b.CondEx,   1);
        chk("b_post_regw",   b.RegWrite, 1);
        chk("b_post_taken",  b.TakenCnt, 1);
        b.Valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_unit_pipe.md
Name: cond_unit_pipe

Overview:
Parametrised execute-stage conditional unit for the ARMv4 core. It owns the architectural NZCV flag register, with separate write enables for the NZ and CV groups. It evaluates the 4-bit condition field against the stored flags and gates the instruction's side effects: PC write, register write, memory write and the flag update itself. Beyond plain condition decode, it adds pipeline stall/flush handling, an optional registered output stage, an undefined-condition flag and saturating taken/skipped counters for performance monitoring.

Parameters:
REG_OUT, 0, 0 = gated outputs are combinational from inputs and stored flags; 1 = gated outputs are registered, adding one cycle of latency.
CNT_W, 16, width of the TakenCnt and SkipCnt counters (range 1..32).
FLAGS_RST, 4'b0000, reset value of the NZCV register.

Ports:
clk  in  1  core clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
Valid  in  1  instruction in execute stage is real (not a bubble).
Stall  in  1  execute stage held; no state change.
Flush  in  1  squash the current execute instruction.
Cond  in  4  instruction condition field [31:28].
ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
FlagW  in  2  bit1 = write NZ group, bit0 = write CV group.
PCS  in  1  instruction writes PC.
RegW  in  1  instruction writes register file.
MemW  in  1  instruction writes memory.
NoWrite  in  1  compare-class op; suppress RegW even if condition passes.
PCSrc  out  1  gated PC write.
RegWrite  out  1  gated register write.
MemWrite  out  1  gated memory write.
CondEx  out  1  condition passed for a live instruction.
Undef  out  1  Cond = 4'b1111 on a live instruction.
Flags  out  4  current NZCV register contents.
TakenCnt  out  CNT_W  live instructions with the condition passed.
SkipCnt  out  CNT_W  live instructions with the condition failed or undefined.

Behaviour:
- live = Valid & ~Stall & ~Flush.
- Condition evaluation uses the stored Flags, never ALUFlags. ge = (N == V).
- Condition mapping:
  - 0000 EQ = Z; 0001 NE = ~Z.
  - 0010 CS = C; 0011 CC = ~C.
  - 0100 MI = N; 0101 PL = ~N.
  - 0110 VS = V; 0111 VC = ~V.
  - 1000 HI = C & ~Z; 1001 LS = ~(C & ~Z).
  - 1010 GE = ge; 1011 LT = ~ge.
  - 1100 GT = ~Z & ge; 1101 LE = ~(~Z & ge).
  - 1110 AL = 1.
  - 1111: pass = 0, Undef = live. This is never X.
- Gated outputs:
  - CondEx = live & pass.
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update on a clock edge when CondEx = 1:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - A group whose FlagW bit is 0 holds its value.
- An update is visible on Flags and used for evaluation in the next cycle; there is no same-cycle bypass.
- Stall = 1: Flags, counters and registered outputs hold; gated outputs are 0 in REG_OUT=0.
- Flush = 1: treated as a bubble. Flush wins over Stall.
- REG_OUT = 1:
  - PCSrc/RegWrite/MemWrite/CondEx/Undef are captured each non-stalled edge and appear 1 cycle later.
  - Flush clears the output register on that edge.
  - Flags timing is unchanged.
- Counters: on each live edge, TakenCnt += pass and SkipCnt += ~pass. Both saturate at all-ones with no wrap.
- reset (async, any time):
  - Flags = FLAGS_RST; counters = 0; all gated outputs and Undef = 0.
  - Any in-flight flag update is discarded.
  - First evaluation after deassertion uses FLAGS_RST.

Decomposition:
- Package cond_pkg:
  - cond_e enum holding the 16 encodings.
  - Flag bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - FLAGW_NZ=1, FLAGW_CV=0.
- Sub-module cond_eval: purely combinational (Cond, Flags) -> (pass, undef).
- The top level holds the flag register, gating, optional output register and counters.

Test Plan:
- Reset, then Valid, Cond=1110, PCS=RegW=1, FlagW=11, ALUFlags=0100 -> PCSrc=RegWrite=CondEx=1 same cycle; Flags=0100 next cycle; TakenCnt=1.
- Flags=0100, Cond=0000 then Cond=0001 -> CondEx=1 then 0; SkipCnt increments on the second instruction only.
- FlagW=10 with ALUFlags=1011 over Flags=0100 -> Flags=1000, CV held; then Cond=1011 (LT) -> CondEx=1.
- Cond=1111, Valid=1 -> Undef=1, CondEx=0, no write outputs, Flags unchanged.
- Stall=1 with Cond=1110, FlagW=11 -> all gated outputs 0; Flags and counters unchanged. Same with Flush=1.
- REG_OUT=1 variant: AL instruction -> RegWrite=1 exactly one cycle later; reset mid-sequence clears outputs and Flags asynchronously. CNT_W=2: 5 taken instructions -> TakenCnt saturates at 3.
